// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - fetchState_e : fetch FSM states (REQ, VALID, HALT)
//   - NOP_INSTR    : instruction presented after reset (addi x0, x0, 0)
//   - OP_LSB/OP_MSB: bit range of the opcode field inside an instruction
//   - PC_STEP      : sequential PC increment in bytes
//   - isMisaligned : true when the two low address bits are not word aligned
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetchState_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          OP_LSB    = 0;
    localparam int          OP_MSB    = 6;
    localparam int          PC_STEP   = 4;

    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return (lowBits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter flop for the fetch stage.
// Ports:
//   clk    - core clock, rising edge
//   rst    - asynchronous active-high reset, loads RESET_PC
//   load   - capture nextPc at this edge
//   nextPc - selected next program counter value
//   pc     - current program counter
// -----------------------------------------------------------------------------
module pc_register #(
    parameter int             AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] nextPc,
    output logic [AW-1:0] pc
);

    // PC storage: reset value or load-enabled update, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= nextPc;
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, reads instruction memory with a
// req/ack handshake and hands the captured instruction to the decoder with a
// valid/ready handshake. Next PC (PC+4 or branch target) is chosen when the
// core consumes the instruction.
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN - when defined, a taken branch to a target whose
//   low two bits are non-zero halts the stage and raises a sticky fetch_fault.
//   When undefined, the target is forced to word alignment and fetch_fault
//   is constant 0.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   imem_req/imem_addr    - instruction read request and word address (= PC)
//   imem_ack/imem_rdata   - read completion and instruction word
//   instr_valid/ready     - handshake towards the core
//   Instr, Op             - captured instruction and its opcode field
//   PC, PCPlus4           - address of Instr and the sequential successor
//   PCSrc, PCTarget       - branch select and target, used at consume edge
//   fetch_fault           - sticky misaligned-target fault
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = AW'(32'h0000_0000)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   Instr,
    output logic [6:0]    Op,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] PCPlus4,
    input  logic          PCSrc,
    input  logic [AW-1:0] PCTarget,
    output logic          fetch_fault
);

    fetchState_e   curState;
    fetchState_e   nextState;
    logic          pcLoad;
    logic          captureInstr;
    logic [31:0]   instrReg;
    logic [AW-1:0] pcPlus4;
    logic [AW-1:0] targetWord;
    logic [AW-1:0] nextPc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic enterHalt;
    logic faultReg;
`endif

    // Sequential successor wraps modulo 2^AW without any flag
    assign pcPlus4 = PC + AW'(PC_STEP);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned targets never reach the PC (the FSM halts instead)
    assign targetWord = PCTarget;
`else
    // Low two bits cleared so a branch always lands on a word boundary
    assign targetWord = PCTarget & ~{{(AW-2){1'b0}}, 2'b11};
`endif

    assign nextPc = PCSrc ? targetWord : pcPlus4;

    pc_register #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pcRegister (
        .clk    (clk),
        .rst    (rst),
        .load   (pcLoad),
        .nextPc (nextPc),
        .pc     (PC)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= REQ;
        end else begin
            curState <= nextState;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        nextState    = curState;
        pcLoad       = 1'b0;
        captureInstr = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        enterHalt    = 1'b0;
`endif
        case (curState)
            REQ: begin
                if (imem_ack) begin
                    nextState    = VALID;
                    captureInstr = 1'b1;
                end else begin
                    nextState    = REQ;
                end
            end
            VALID: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (PCSrc && isMisaligned(PCTarget[1:0])) begin
                        nextState = HALT;
                        enterHalt = 1'b1;
                    end else begin
                        nextState = REQ;
                        pcLoad    = 1'b1;
                    end
`else
                    nextState = REQ;
                    pcLoad    = 1'b1;
`endif
                end else begin
                    nextState = VALID;
                end
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = REQ;
            end
        endcase
    end

    // Instruction capture: only the accepting ack edge changes Instr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrReg <= NOP_INSTR;
        end else if (captureInstr) begin
            instrReg <= imem_rdata;
        end else begin
            instrReg <= instrReg;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            faultReg <= 1'b0;
        end else if (enterHalt) begin
            faultReg <= 1'b1;
        end else begin
            faultReg <= faultReg;
        end
    end

    assign fetch_fault = faultReg;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = (curState == REQ);
    assign imem_addr   = PC;
    assign instr_valid = (curState == VALID);
    assign Instr       = instrReg;
    assign Op          = instrReg[OP_MSB:OP_LSB];
    assign PCPlus4     = pcPlus4;

endmodule
